serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_pkg.sv | 13 +
 rtl/serial_add_ctrl_fa_cell.sv | 13 +
 rtl/serial_add_ctrl.sv | 143 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding
// and the default operand width.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single-bit full adder: the only arithmetic element of the serial adder.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. Adds two WIDTH-bit operands plus carry-in,
// LSB first, through one full-adder cell and a carry flip-flop.
// Optional build macro SERIAL_ADD_OVF_EN adds a signed-overflow output.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic               fa_s;
  logic               fa_co;

  fa_cell u_fa (
    .x  (opa_q[0]),
    .y  (opb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state and datapath control: one operand bit pair per RUN cycle.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        // A start seen in DONE is accepted just like in IDLE, giving
        // back-to-back operation without an idle bubble.
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_co;
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          // Final bit: carry_q is the carry into the MSB, fa_co the carry out.
          cnt_d   = '0;
          cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ fa_co;
`endif
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8). Define SERIAL_ADD_OVF_EN
// to also exercise the signed-overflow output.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W:0] res;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop an expectation whenever the DUT presents a result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      check("done_single_cycle", 32'(prev_done), 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done with sum=0x%0h, expected no done", sum);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum", 32'(sum), 32'(e.res[W-1:0]));
        check("cout", 32'(cout), 32'(e.res[W]));
        check("latency", 32'(cyc - e.cyc), 32'(W));
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end
    prev_done = done;
  end

  // Wait for an accepting cycle, present operands, record the expectation.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input logic [W:0] er, input logic eo, input bit hold);
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: busy still 1, expected 0 within 40 cycles");
      return;
    end
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{er, eo, cyc});
    if (!hold) start = 1'b0;
  endtask

  initial begin
    logic [W:0]   r;
    logic [W-1:0] bv;
    logic         cv;
    logic         ov;
    int           nb;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;

    // 1: basic add, busy for exactly 8 cycles
    do_op(8'h0F, 8'h01, 1'b0, 9'h010, 1'b0, 1'b0);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) break;
      if (busy) nb++;
    end
    check("busy_cycles", 32'(nb), 32'd8);

    // 2: directed corner values, then full {cin,b} sweep with a=C3
    do_op(8'hFF, 8'h00, 1'b1, 9'h100, 1'b0, 1'b0);
    do_op(8'hAA, 8'h55, 1'b0, 9'h0FF, 1'b0, 1'b0);
    for (int i = 0; i < 512; i++) begin
      bv = i[7:0];
      cv = i[8];
      r  = 9'(8'hC3) + 9'(bv) + 9'(cv);
      ov = (bv[7] == 1'b1) && (r[7] != 1'b1);
      do_op(8'hC3, bv, cv, r, ov, 1'b0);
    end

    // 3: start pulsed during RUN cycle 3 must be ignored
    do_op(8'h01, 8'h01, 1'b0, 9'h002, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 8'hF0; b = 8'hF0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    // 4: start held high, operands change at each accepting edge
    do_op(8'h3C, 8'hC3, 1'b0, 9'h0FF, 1'b0, 1'b1);
    do_op(8'h80, 8'h7F, 1'b1, 9'h100, 1'b0, 1'b1);
    do_op(8'h64, 8'h64, 1'b0, 9'h0C8, 1'b1, 1'b1);
    do_op(8'h9C, 8'h9C, 1'b1, 9'h139, 1'b1, 1'b0);

    // 5: reset during RUN cycle 4 aborts with no done
    repeat (12) @(posedge clk);
    @(negedge clk);
    a = 8'h55; b = 8'h11; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    repeat (12) @(posedge clk);
    do_op(8'h12, 8'h34, 1'b0, 9'h046, 1'b0, 1'b0);

`ifdef SERIAL_ADD_OVF_EN
    // 6: signed overflow
    do_op(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1, 1'b0);
    do_op(8'h80, 8'h80, 1'b0, 9'h100, 1'b1, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0, 1'b0);
`endif

    repeat (20) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
